// File: rtl/bft_seq_pkg.sv
// Shared types and defaults for the bft command sequencer.
package bft_seq_pkg;

  localparam int unsigned SEQ_CMD_W    = 6;
  localparam int unsigned SEQ_DLY_W    = 8;
  localparam int unsigned SEQ_IDLE_CMD = 0;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_WAIT   = 3'd1;
  localparam state_t ST_ISSUE  = 3'd2;
  localparam state_t ST_DRAIN  = 3'd3;
  localparam state_t ST_FINISH = 3'd4;

  typedef struct packed {
    logic [SEQ_CMD_W-1:0] cmd;
    logic [SEQ_DLY_W-1:0] dly;
  } entry_t;

endpackage

// File: rtl/bft_seq_table.sv
// Script table: one write port, one combinational read port with write-first forwarding.
module bft_seq_table #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned W     = 14,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata_c
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // A write and a read of the same slot in one cycle returns the new data.
  assign rdata_c = (we && (waddr == raddr)) ? wdata : mem[raddr];

endmodule

// File: rtl/bft_cmd_sequencer.sv
// Programmable (delay, cmd) script player for the bft NoC with done_all / timeout wrap-up.
module bft_cmd_sequencer
  import bft_seq_pkg::*;
#(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned CMD_W    = SEQ_CMD_W,
  parameter int unsigned DLY_W    = SEQ_DLY_W,
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned TIMEOUT  = 1024,
  parameter int unsigned IDLE_CMD = SEQ_IDLE_CMD,
  localparam int unsigned IW      = $clog2(DEPTH),
  localparam int unsigned NW      = IW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             wr_en,
  input  logic [IW-1:0]    wr_addr,
  input  logic [CMD_W-1:0] wr_cmd,
  input  logic [DLY_W-1:0] wr_dly,
  input  logic [NW-1:0]    num_entries,
  input  logic             start,
  input  logic             abort,
  input  logic             done_all,
  output logic [CMD_W-1:0] cmd,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timed_out,
  output logic             aborted,
  output logic [CNT_W-1:0] cycles
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned EW = CMD_W + DLY_W;

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d, rd_idx;
  logic [NW-1:0]    num_q, num_d;
  logic [DLY_W-1:0] dcnt_q, dcnt_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic [CMD_W-1:0] cmd_d;
  logic             busy_d, done_d, pass_d, to_d, ab_d;
  logic [CNT_W-1:0] cyc_d;
  logic             enter, tbl_we;
  logic [EW-1:0]    rd_data;
  logic [CMD_W-1:0] rd_cmd;
  logic [DLY_W-1:0] rd_dly;

  assign tbl_we = ce && wr_en && (state_q == ST_IDLE);
  assign rd_cmd = rd_data[EW-1:DLY_W];
  assign rd_dly = rd_data[DLY_W-1:0];

  bft_seq_table #(.DEPTH(DEPTH), .W(EW)) u_table (
    .clk     (clk),
    .we      (tbl_we),
    .waddr   (wr_addr),
    .wdata   ({wr_cmd, wr_dly}),
    .raddr   (rd_idx),
    .rdata_c (rd_data)
  );

  // State register; ce=0 freezes every register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      num_q     <= '0;
      dcnt_q    <= '0;
      tcnt_q    <= '0;
      cmd       <= CMD_W'(IDLE_CMD);
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      timed_out <= 1'b0;
      aborted   <= 1'b0;
      cycles    <= '0;
    end else if (ce) begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      num_q     <= num_d;
      dcnt_q    <= dcnt_d;
      tcnt_q    <= tcnt_d;
      cmd       <= cmd_d;
      busy      <= busy_d;
      done      <= done_d;
      pass      <= pass_d;
      timed_out <= to_d;
      aborted   <= ab_d;
      cycles    <= cyc_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    num_d   = num_q;
    dcnt_d  = dcnt_q;
    tcnt_d  = tcnt_q;
    cmd_d   = CMD_W'(IDLE_CMD);
    pass_d  = pass;
    to_d    = timed_out;
    ab_d    = aborted;
    cyc_d   = cycles;
    rd_idx  = idx_q;
    enter   = 1'b0;

    if ((state_q == ST_WAIT || state_q == ST_ISSUE || state_q == ST_DRAIN) && (cycles != '1))
      cyc_d = cycles + CNT_W'(1);

    case (state_q)
      ST_IDLE: begin
        rd_idx = '0;
        if (start && !abort) begin
          pass_d = 1'b0;
          to_d   = 1'b0;
          ab_d   = 1'b0;
          cyc_d  = CNT_W'(1);
          if ((num_entries != '0) && (num_entries <= NW'(DEPTH))) begin
            num_d = num_entries;
            idx_d = '0;
            enter = 1'b1;
          end else begin
            state_d = ST_FINISH;
          end
        end
      end
      ST_WAIT: begin
        if (abort) begin
          state_d = ST_FINISH;
        end else begin
          dcnt_d = dcnt_q - DLY_W'(1);
          if (dcnt_q == DLY_W'(1)) begin
            state_d = ST_ISSUE;
            cmd_d   = rd_cmd;
          end
        end
      end
      ST_ISSUE: begin
        rd_idx = idx_q + IW'(1);
        if (abort) begin
          state_d = ST_FINISH;
        end else if (({1'b0, idx_q} + NW'(1)) == num_q) begin
          state_d = ST_DRAIN;
          tcnt_d  = '0;
        end else begin
          idx_d = idx_q + IW'(1);
          enter = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (abort) begin
          state_d = ST_FINISH;
        end else if (done_all) begin
          state_d = ST_FINISH;
          pass_d  = 1'b1;
        end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
          state_d = ST_FINISH;
          to_d    = 1'b1;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    if (abort && (state_q == ST_WAIT || state_q == ST_ISSUE || state_q == ST_DRAIN)) begin
      ab_d   = 1'b1;
      pass_d = 1'b0;
      to_d   = 1'b0;
    end

    // Entering an entry: zero delay issues straight away, otherwise wait dly cycles.
    if (enter) begin
      if (rd_dly == '0) begin
        state_d = ST_ISSUE;
        cmd_d   = rd_cmd;
      end else begin
        state_d = ST_WAIT;
        dcnt_d  = rd_dly;
      end
    end

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_FINISH);
  end

endmodule

// File: tb/tb_bft_cmd_sequencer.sv
// Directed self-checking bench for bft_cmd_sequencer (DEPTH=16, TIMEOUT=16).
module tb_bft_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst, ce, wr_en, start, abort, done_all;
  logic [3:0] wr_addr;
  logic [5:0] wr_cmd;
  logic [7:0] wr_dly;
  logic [4:0] num_entries;
  logic [5:0] cmd;
  logic       busy, done, pass, timed_out, aborted;
  logic [31:0] cycles;

  int n_cmp = 0;
  int n_bad = 0;

  logic [5:0]  lg_cmd  [64];
  logic        lg_done [64];
  logic        lg_busy [64];
  logic        lg_pass [64];
  logic        lg_to   [64];
  logic        lg_ab   [64];
  logic [31:0] lg_cyc  [64];

  always #5 clk = ~clk;

  bft_cmd_sequencer #(.DEPTH(16), .CMD_W(6), .DLY_W(8), .CNT_W(32),
                      .TIMEOUT(16), .IDLE_CMD(0)) dut (
    .clk(clk), .rst(rst), .ce(ce), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_cmd(wr_cmd), .wr_dly(wr_dly), .num_entries(num_entries),
    .start(start), .abort(abort), .done_all(done_all),
    .cmd(cmd), .busy(busy), .done(done), .pass(pass),
    .timed_out(timed_out), .aborted(aborted), .cycles(cycles)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int addr, input int c, input int d);
    wr_en = 1'b1; wr_addr = 4'(addr); wr_cmd = 6'(c); wr_dly = 8'(d);
    tick();
    wr_en = 1'b0;
  endtask

  // Start at cycle 0, log outputs for cycles 1..maxc; hooks < 0 are unused.
  task automatic run(input int n, input int maxc, input int done_at, input int abort_at,
                     input int intr_at, input int ce_from, input int ce_to);
    num_entries = 5'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= maxc; c++) begin
      lg_cmd[c] = cmd; lg_done[c] = done; lg_busy[c] = busy;
      lg_pass[c] = pass; lg_to[c] = timed_out; lg_ab[c] = aborted; lg_cyc[c] = cycles;
      done_all = (c == done_at);
      abort    = (c == abort_at);
      ce       = !(c >= ce_from && c <= ce_to);
      wr_en    = (c == intr_at);
      start    = (c == intr_at);
      if (c == intr_at) begin
        wr_addr = 4'd1; wr_cmd = 6'd33; wr_dly = 8'd0;
      end
      tick();
    end
    done_all = 1'b0; abort = 1'b0; ce = 1'b1; wr_en = 1'b0; start = 1'b0;
  endtask

  function automatic int first_done(input int maxc);
    for (int c = 1; c <= maxc; c++) if (lg_done[c]) return c;
    return -1;
  endfunction

  function automatic int count_active(input int maxc);
    int k = 0;
    for (int c = 1; c <= maxc; c++) if (lg_cmd[c] != 6'd0) k++;
    return k;
  endfunction

  function automatic int count_val(input int maxc, input int v);
    int k = 0;
    for (int c = 1; c <= maxc; c++) if (lg_cmd[c] == 6'(v)) k++;
    return k;
  endfunction

  initial begin
    int fd;
    rst = 1'b1; ce = 1'b1; wr_en = 1'b0; start = 1'b0; abort = 1'b0; done_all = 1'b0;
    wr_addr = '0; wr_cmd = '0; wr_dly = '0; num_entries = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_cmd", 32'(cmd), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_flags", {29'd0, pass, timed_out, aborted}, 0);
    chk("rst_cycles", cycles, 0);

    // Basic two-entry script
    load(0, 3, 10); load(1, 5, 3);
    run(2, 40, 30, -1, -1, -1, -1);
    chk("t1_cmd3", 32'(lg_cmd[11]), 3);
    chk("t1_cmd5", 32'(lg_cmd[15]), 5);
    chk("t1_active", 32'(count_active(40)), 2);
    fd = first_done(40);
    chk("t1_done_t", 32'(fd), 31);
    chk("t1_pass", 32'(lg_pass[31]), 1);
    chk("t1_cycles", lg_cyc[31], 31);
    chk("t1_cyc_hold", lg_cyc[40], 31);
    chk("t1_busy_end", 32'(lg_busy[32]), 0);

    // Zero delays, back-to-back issue
    load(0, 1, 0); load(1, 2, 0); load(2, 3, 0); load(3, 4, 0);
    run(4, 12, 6, -1, -1, -1, -1);
    for (int c = 1; c <= 4; c++) chk($sformatf("t2_cmd%0d", c), 32'(lg_cmd[c]), 32'(c));
    chk("t2_after", 32'(lg_cmd[5]), 0);
    chk("t2_done_t", 32'(first_done(12)), 7);

    // Timeout
    load(0, 7, 0);
    run(1, 25, -1, -1, -1, -1, -1);
    chk("t3_cmd7", 32'(lg_cmd[1]), 7);
    fd = first_done(25);
    chk("t3_done_t", 32'(fd), 18);
    chk("t3_timed_out", 32'(lg_to[18]), 1);
    chk("t3_pass", 32'(lg_pass[18]), 0);
    chk("t3_cycles", lg_cyc[18], 18);

    // Abort mid-WAIT
    load(0, 9, 50);
    run(1, 30, -1, 20, -1, -1, -1);
    chk("t4_no_cmd9", 32'(count_val(30, 9)), 0);
    chk("t4_done_t", 32'(first_done(30)), 21);
    chk("t4_aborted", 32'(lg_ab[21]), 1);
    chk("t4_busy20", 32'(lg_busy[20]), 1);
    chk("t4_busy22", 32'(lg_busy[22]), 0);

    // Writes and start while busy are ignored
    load(0, 11, 5); load(1, 12, 2);
    run(2, 20, 12, -1, 3, -1, -1);
    chk("t5_cmd11", 32'(lg_cmd[6]), 11);
    chk("t5_cmd12", 32'(lg_cmd[9]), 12);
    chk("t5_active", 32'(count_active(20)), 2);
    chk("t5_done_t", 32'(first_done(20)), 13);
    chk("t5_busy_end", 32'(lg_busy[20]), 0);

    // Empty start
    run(0, 5, -1, -1, -1, -1, -1);
    chk("t5e_done_t", 32'(first_done(5)), 1);
    chk("t5e_pass", 32'(lg_pass[1]), 0);
    chk("t5e_busy2", 32'(lg_busy[2]), 0);

    // ce hold inside WAIT shifts issue by 5
    load(0, 3, 10);
    run(1, 20, -1, -1, -1, 4, 8);
    chk("t6_cmd_early", 32'(lg_cmd[11]), 0);
    chk("t6_cmd_late", 32'(lg_cmd[16]), 3);
    chk("t6_drain_busy", 32'(lg_busy[20]), 1);

    // Asynchronous reset mid-DRAIN
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_cmd", 32'(cmd), 0);
    chk("t6_rst_cycles", cycles, 0);
    tick();
    rst = 1'b0;
    tick();

    // Rerun from stored table; done_all lands on the timeout cycle
    run(1, 32, 27, -1, -1, -1, -1);
    chk("t6_rerun_cmd", 32'(lg_cmd[11]), 3);
    chk("t6_prio_done_t", 32'(first_done(32)), 28);
    chk("t6_prio_pass", 32'(lg_pass[28]), 1);
    chk("t6_prio_to", 32'(lg_to[28]), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bft_cmd_sequencer.md
Name: bft_cmd_sequencer

Overview:
- Programmable command sequencer for the bft NoC. Replaces hard-coded time-indexed command scripts.
- Holds a small table of (delay, cmd) entries and issues each cmd for exactly one cycle after its delay.
- After the last entry it waits for the bft done_all, or for a timeout. It then reports pass/timeout and the elapsed cycle count.
- Sits between a host/bench loader and the bft cmd / done_all pins.

Parameters:
- DEPTH, 16, number of script entries (power of 2).
- CMD_W, 6, command width; matches bft cmd.
- DLY_W, 8, per-entry delay width, in cycles.
- CNT_W, 32, width of the elapsed-cycle counter.
- TIMEOUT, 1024, max cycles spent in DRAIN before declaring timeout.
- IDLE_CMD, 0, command code driven when no command is issued (Cmd_IDLE encoding).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- ce  in  1  clock enable; 0 freezes all state, outputs hold.
- wr_en  in  1  table write strobe; honoured only in IDLE.
- wr_addr  in  $clog2(DEPTH)  table index.
- wr_cmd  in  CMD_W  command to store.
- wr_dly  in  DLY_W  idle cycles before this command.
- num_entries  in  $clog2(DEPTH)+1  script length; sampled on start.
- start  in  1  begin script, single-cycle pulse.
- abort  in  1  terminate script.
- done_all  in  1  from bft.
- cmd  out  CMD_W  to bft cmd; registered.
- busy  out  1  high in any non-IDLE state.
- done  out  1  one-cycle pulse at script end.
- pass  out  1  sticky: done_all seen.
- timed_out  out  1  sticky: TIMEOUT expired.
- aborted  out  1  sticky: abort taken.
- cycles  out  CNT_W  cycles from start to done; saturates at all-ones.

Behaviour:
- Reset values: state=IDLE, cmd=IDLE_CMD, busy=0, done=0, pass=0, timed_out=0, aborted=0, cycles=0, all counters 0. Table contents are not reset.
- States: IDLE, WAIT, ISSUE, DRAIN, FINISH. All transitions require ce=1.
- IDLE
  - wr_en writes table[wr_addr].
  - start with num_entries in 1..DEPTH: latch the length, set idx=0, clear pass/timed_out/aborted/cycles, enter entry 0.
  - start with num_entries=0 or >DEPTH: go to FINISH directly, pass=0.
  - Write and start in the same cycle: the write lands first, so entry reads see the new value.
- Entering entry k: if dly_k==0, go to ISSUE; otherwise go to WAIT with dcnt=dly_k.
- WAIT
  - cmd=IDLE_CMD; dcnt decrements.
  - At dcnt==1, go to ISSUE. WAIT lasts exactly dly_k cycles.
- ISSUE
  - cmd=cmd_k for exactly one cycle.
  - If k is the last entry, go to DRAIN with tcnt=0; otherwise set idx=k+1 and enter the next entry.
- Timing: with start sampled at cycle t, cmd_k appears at cycle t+1+sum(dly_0..dly_k)+k.
- DRAIN
  - cmd=IDLE_CMD; tcnt increments each cycle.
  - done_all=1: go to FINISH, pass=1.
  - Otherwise, tcnt==TIMEOUT-1: go to FINISH, timed_out=1.
  - done_all and timeout in the same cycle: pass wins.
- done_all outside DRAIN is ignored.
- FINISH: done=1 for one cycle, cycles frozen, then IDLE. pass/timed_out/aborted hold until the next start.
- cycles counts every ce cycle while busy, starting at 1 in the first cycle after start.
- abort in WAIT/ISSUE/DRAIN: go to FINISH next cycle, cmd=IDLE_CMD immediately, aborted=1, pass=0, timed_out=0.
  - abort in IDLE or FINISH is ignored.
  - abort and start together in IDLE: abort wins, so nothing starts.
- start while busy is ignored. wr_en while busy is ignored.
- rst mid-script: immediate return to reset values; the table is preserved.

Decomposition:
- Package bft_seq_pkg:
  - state enum {IDLE, WAIT, ISSUE, DRAIN, FINISH};
  - entry struct {cmd, dly};
  - IDLE_CMD default.
- Sub-module bft_seq_table: DEPTH x (CMD_W+DLY_W) register file.
  - 1 write port, 1 async read port indexed by idx.
  - Behavioural regs, so the table reads combinationally within the cycle.

Test Plan:
- Basic two-entry script.
  - Stimulus: load {dly=10, cmd=3}, {dly=3, cmd=5}; num_entries=2; start at t=0; done_all at t=30.
  - Required: cmd=3 only at t=11, cmd=5 only at t=15; done pulse at t=31; pass=1; cycles=31.
- Zero delays.
  - Stimulus: four entries, dly=0, cmds 1,2,3,4.
  - Required: cmd=1,2,3,4 on t=1..4, consecutive, no IDLE gaps.
- Timeout.
  - Stimulus: TIMEOUT=16, one entry dly=0 cmd=7; done_all never asserts.
  - Required: cmd=7 at t=1; done at t=18; timed_out=1; pass=0.
- Abort.
  - Stimulus: entry {dly=50, cmd=9}; abort at t=20.
  - Required: cmd never equals 9; done at t=21; aborted=1; busy=0 at t=22.
- Ignored inputs while busy and empty start.
  - Stimulus: wr_en and start asserted while busy; separately, start with num_entries=0.
  - Required: busy run's table and sequence are unchanged; empty start pulses done after 1 cycle with pass=0.
- Reset, ce hold, and pass priority.
  - Stimulus: ce=0 for 5 cycles inside WAIT; rst asserted mid-DRAIN; done_all and timeout expiry in the same cycle.
  - Required: issue time shifts by +5; rst returns outputs to reset values asynchronously, and the rerun uses the stored table; simultaneous case gives pass=1, timed_out=0.
